// File: rtl/riscv_dmem_pkg.sv
// Shared types and constants for the multi-cycle RISC-V data memory controller.
package riscv_dmem_pkg;

    localparam int unsigned DW_W  = 64;
    localparam int unsigned LANES = DW_W / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        SB = 2'b00,
        SH = 2'b01,
        SW = 2'b10,
        SD = 2'b11
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/riscv_dmem_lane_mask.sv
// Store size/offset to byte-lane mask and lane-aligned write data.
// RISCV_DMEM_MISALIGN_EN: keep the raw offset (misaligned stores are blocked upstream);
// otherwise the offset is forced down to the access-size alignment.
module riscv_dmem_lane_mask
    import riscv_dmem_pkg::*;
(
    input  store_size_e      size,
    input  logic [2:0]       offset,
    input  logic [DW_W-1:0]  wdata,
    output logic [LANES-1:0] mask_c,
    output logic [DW_W-1:0]  wdata_sh_c,
    output logic             misaligned_c
);

    logic [2:0]       lane_off;
    logic [LANES-1:0] base_mask;

`ifdef RISCV_DMEM_MISALIGN_EN
    assign lane_off = offset;
`else
    always_comb begin
        lane_off = offset;
        unique case (size)
            SB: lane_off = offset;
            SH: lane_off = {offset[2:1], 1'b0};
            SW: lane_off = {offset[2], 2'b00};
            SD: lane_off = 3'b000;
        endcase
    end
`endif

    // Base lane pattern and natural-alignment test per access size.
    always_comb begin
        base_mask    = '0;
        misaligned_c = 1'b0;
        unique case (size)
            SB: base_mask = 8'h01;
            SH: begin
                base_mask    = 8'h03;
                misaligned_c = offset[0];
            end
            SW: begin
                base_mask    = 8'h0F;
                misaligned_c = |offset[1:0];
            end
            SD: begin
                base_mask    = 8'hFF;
                misaligned_c = |offset;
            end
        endcase
    end

    assign mask_c     = LANES'(base_mask << lane_off);
    assign wdata_sh_c = DW_W'(wdata << {lane_off, 3'b000});

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Parametrised data memory with LATENCY stall cycles per access and byte-masked stores.
// RISCV_DMEM_MISALIGN_EN: flag and suppress misaligned stores instead of aligning them.
module riscv_dmem_ctrl
    import riscv_dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic              i_riscv_dmem_clk,
    input  logic              i_riscv_dmem_rst,
    input  logic              i_riscv_dmem_wren,
    input  logic              i_riscv_dmem_rden,
    input  logic [1:0]        i_riscv_dmem_storesrc,
    input  logic [ADDR_W-1:0] i_riscv_dmem_addr,
    input  logic [DW_W-1:0]   i_riscv_dmem_wdata,
    output logic [DW_W-1:0]   o_riscv_dmem_rdata,
    output logic              o_riscv_dmem_stall,
    output logic              o_riscv_dmem_misaligned
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 req_c, commit_c, stall_c;
    logic [IDX_W-1:0]     idx;
    logic [LANES-1:0]     mask_c, wmask_c;
    logic [DW_W-1:0]      wdata_sh_c, merged_c, rdata_q;
    logic                 mis_c, wr_block_c;
    logic [DW_W-1:0]      mem [DEPTH];

    assign idx   = i_riscv_dmem_addr[IDX_W+2:3];
    assign req_c = (i_riscv_dmem_wren | i_riscv_dmem_rden) & i_riscv_dmem_rst;

    logic unused_addr;
    assign unused_addr = ^i_riscv_dmem_addr[ADDR_W-1:IDX_W+3];

    riscv_dmem_lane_mask u_lane_mask (
        .size         (store_size_e'(i_riscv_dmem_storesrc)),
        .offset       (i_riscv_dmem_addr[2:0]),
        .wdata        (i_riscv_dmem_wdata),
        .mask_c       (mask_c),
        .wdata_sh_c   (wdata_sh_c),
        .misaligned_c (mis_c)
    );

`ifdef RISCV_DMEM_MISALIGN_EN
    logic mis_q;
    assign wr_block_c = mis_c;

    always_ff @(posedge i_riscv_dmem_clk or negedge i_riscv_dmem_rst) begin
        if (!i_riscv_dmem_rst) mis_q <= 1'b0;
        else                   mis_q <= commit_c & i_riscv_dmem_wren & mis_c;
    end
    assign o_riscv_dmem_misaligned = mis_q;
`else
    logic unused_mis;
    assign unused_mis              = mis_c;
    assign wr_block_c              = 1'b0;
    assign o_riscv_dmem_misaligned = 1'b0;
`endif

    // State and wait-counter registers.
    always_ff @(posedge i_riscv_dmem_clk or negedge i_riscv_dmem_rst) begin
        if (!i_riscv_dmem_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, stall and commit strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_c  = 1'b0;
        commit_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_c) begin
                    stall_c = 1'b1;
                    if (LATENCY == 1) begin
                        commit_c = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_riscv_dmem_stall = stall_c;

    // Merge shifted store data into the addressed doubleword lane by lane.
    assign wmask_c = mask_c & {LANES{~wr_block_c}};
    always_comb begin
        merged_c = mem[idx];
        for (int i = 0; i < int'(LANES); i++) begin
            if (wmask_c[i]) merged_c[8*i +: 8] = wdata_sh_c[8*i +: 8];
        end
    end

    always_ff @(posedge i_riscv_dmem_clk) begin
        if (commit_c && i_riscv_dmem_wren && !wr_block_c) mem[idx] <= merged_c;
    end

    always_ff @(posedge i_riscv_dmem_clk or negedge i_riscv_dmem_rst) begin
        if (!i_riscv_dmem_rst)  rdata_q <= '0;
        else if (commit_c)      rdata_q <= i_riscv_dmem_wren ? merged_c : mem[idx];
    end

    assign o_riscv_dmem_rdata = rdata_q;

endmodule

// File: doc/riscv_dmem_ctrl.md
# riscv_dmem_ctrl

Parametrised data memory with configurable access latency and a stall handshake, next generation of the single-cycle data memory. Sits behind the core's memory stage, or behind the data cache as its backing store. Adds multi-cycle wait states, a four-size store path with byte-lane masking and a doubleword read return. Depth, address width and latency are parameters.

## Interface
- DEPTH, 1024 — number of 64-bit doublewords; power of two, ≥ 2
- ADDR_W, 64 — byte-address width
- LATENCY, 2 — stall cycles per access; legal range 1..15
- i_riscv_dmem_clk  in  1  single clock, all state on rising edge
- i_riscv_dmem_rst  in  1  reset, asynchronous, active-low
- i_riscv_dmem_wren  in  1  store request, held stable while o_riscv_dmem_stall=1
- i_riscv_dmem_rden  in  1  load request, held stable while stalled
- i_riscv_dmem_storesrc  in  2  store size: 00 byte, 01 half, 10 word, 11 double
- i_riscv_dmem_addr  in  ADDR_W  byte address
- i_riscv_dmem_wdata  in  64  store data, right-aligned (valid bits in LSBs)
- o_riscv_dmem_rdata  out  64  aligned doubleword containing addr, registered
- o_riscv_dmem_stall  out  1  core must freeze; request must stay stable
- o_riscv_dmem_misaligned  out  1  misaligned-store flag (macro-dependent)

## Operation
- FSM states IDLE, WAIT, DONE. Reset → IDLE.
- IDLE, no request: stall=0. IDLE with wren|rden: stall=1 combinationally in that cycle. If LATENCY=1, access commits at this edge → DONE. Otherwise cnt ← LATENCY-2 → WAIT.
- WAIT: stall=1. cnt=0: access commits at this edge → DONE. Else cnt decrements.
- DONE: stall=0, o_rdata valid, core advances at this edge. Always → IDLE; request inputs ignored in DONE.
- Index = addr[log2(DEPTH)+2:3]. Higher address bits are ignored, so addresses wrap modulo DEPTH·8.
- Store: byte mask by size and addr[2:0]. wdata is shifted left by 8·addr[2:0]; only masked lanes are written.
- Load: o_rdata ← full doubleword at index. Sign/zero extraction is done in the core.
- wren and rden both high: treated as a store. o_rdata returns the post-write doubleword.
- o_rdata holds its last value until the next committed access. A store also updates o_rdata with the merged doubleword.
- Memory array is not reset.

## Timing
- Reset values: o_rdata=0, stall=0, misaligned=0, state IDLE, cnt=0.
- Request in cycle 0: stall high for cycles 0..LATENCY-1. Commit at the edge ending cycle LATENCY-1. DONE in cycle LATENCY with data valid.
- Back-to-back requests: the next request is seen earliest in cycle LATENCY+1 (IDLE). Throughput is one access per LATENCY+1 cycles.
- Reset asserted mid-access: immediate return to IDLE, stall=0, no write committed.

## Configuration
- RISCV_DMEM_MISALIGN_EN defined:
  - A store is misaligned when: half with addr[0]≠0, word with addr[1:0]≠0, or double with addr[2:0]≠0.
  - A misaligned store writes nothing and o_misaligned=1 only in its DONE cycle.
  - Loads are unaffected.
- Macro undefined:
  - The address is forced down to the access-size alignment before masking.
  - o_misaligned is tied 0.

## Structure
- Package riscv_dmem_pkg: store-size enum (SB, SH, SW, SD), FSM state enum, doubleword width constant.
- Sub-module riscv_dmem_lane_mask: combinational size/offset → 8-bit byte mask and shifted wdata; also emits the misalignment condition.
- Top holds the FSM, latency counter, array and rdata register.

## Test plan
- LATENCY=3; load addr 0x10 after preloading 0xDEADBEEF_CAFEF00D → stall high exactly 3 cycles, then rdata=0xDEADBEEF_CAFEF00D in DONE cycle.
- Store byte 0xAB at 0x13 over 0 → doubleword at index 2 reads 0x00000000_AB000000. Then store half 0x1234 at 0x16 → reads 0x12340000_AB000000.
- wren=rden=1, store word 0x89ABCDEF at 0x20 → rdata in DONE = 0x00000000_89ABCDEF.
- DEPTH=16, store double at 0x80 → aliases index 0; load 0x0 returns the same data.
- With macro: store half at 0x21 → no write, misaligned=1 for one cycle. Without macro: write lands at 0x20, misaligned=0.
- Reset pulled low in WAIT of a store → stall drops immediately, target doubleword unchanged, rdata=0.
